// File: rtl/vga_sram_responder.sv
// vga_sram_responder: owns the 512Kx8 asynchronous SRAM. VGA fetches get a
// one-cycle slot whenever they ask, with data valid one edge after the grant.
// The CPU Wishbone byte port uses the slots that VGA leaves idle.
// Optional macro VGA_SRAM_STALL_CNT_EN adds O_stall_cnt, a saturating count of
// edges where a pending CPU strobe lost arbitration to a VGA request.
module vga_sram_responder #(
    parameter int ADR_W = 19,
    parameter int DAT_W = 8
) (
    input  logic             I_vga_clk,
    input  logic             I_reset,
    input  logic             I_vga_req,
    input  logic [ADR_W-1:0] I_vga_adr,
    output logic [DAT_W-1:0] O_vga_dat,
    input  logic [ADR_W-1:0] I_wb_adr,
    input  logic [DAT_W-1:0] I_wb_dat,
    input  logic             I_wb_stb,
    input  logic             I_wb_we,
    output logic             O_wb_ack,
    output logic [DAT_W-1:0] O_wb_dat,
    output logic [ADR_W-1:0] O_sram_adr,
    output logic [DAT_W-1:0] O_sram_dat,
    output logic             O_sram_dat_oe,
    input  logic [DAT_W-1:0] I_sram_dat,
    output logic             O_sram_ce_n,
    output logic             O_sram_oe_n,
    output logic             O_sram_we_n
`ifdef VGA_SRAM_STALL_CNT_EN
    ,
    output logic [15:0]      O_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } state_t;

    state_t             state;
    logic               vga_slot;
    logic               cpu_we;
    logic [DAT_W-1:0]   vga_hold;
    logic               cpu_grant;

    // The CPU only gets the next slot when it is idle and VGA is not asking.
    assign cpu_grant = (state == IDLE) && I_wb_stb && !I_vga_req;

    // During a VGA slot the SRAM data flows straight through; otherwise the
    // last fetched byte is held for the VGA controller.
    assign O_vga_dat = vga_slot ? I_sram_dat : vga_hold;

    // Slot arbitration, registered SRAM pins, CPU handshake FSM and VGA capture.
    always_ff @(posedge I_vga_clk) begin
        if (I_reset) begin
            state         <= IDLE;
            vga_slot      <= 1'b0;
            cpu_we        <= 1'b0;
            vga_hold      <= '0;
            O_wb_ack      <= 1'b0;
            O_wb_dat      <= '0;
            O_sram_adr    <= '0;
            O_sram_dat    <= '0;
            O_sram_dat_oe <= 1'b0;
            O_sram_ce_n   <= 1'b1;
            O_sram_oe_n   <= 1'b1;
            O_sram_we_n   <= 1'b1;
        end else begin
            if (vga_slot) begin
                vga_hold <= I_sram_dat;
            end

            if (I_vga_req) begin
                vga_slot      <= 1'b1;
                O_sram_adr    <= I_vga_adr;
                O_sram_ce_n   <= 1'b0;
                O_sram_oe_n   <= 1'b0;
                O_sram_we_n   <= 1'b1;
                O_sram_dat_oe <= 1'b0;
            end else if (cpu_grant) begin
                vga_slot      <= 1'b0;
                O_sram_adr    <= I_wb_adr;
                O_sram_ce_n   <= 1'b0;
                O_sram_oe_n   <= I_wb_we;
                O_sram_we_n   <= !I_wb_we;
                O_sram_dat_oe <= I_wb_we;
                if (I_wb_we) begin
                    O_sram_dat <= I_wb_dat;
                end
            end else begin
                vga_slot      <= 1'b0;
                O_sram_ce_n   <= 1'b1;
                O_sram_oe_n   <= 1'b1;
                O_sram_we_n   <= 1'b1;
                O_sram_dat_oe <= 1'b0;
            end

            case (state)
                IDLE: begin
                    O_wb_ack <= 1'b0;
                    if (cpu_grant) begin
                        state  <= ACCESS;
                        cpu_we <= I_wb_we;
                    end
                end
                ACCESS: begin
                    state    <= ACK;
                    O_wb_ack <= 1'b1;
                    if (!cpu_we) begin
                        O_wb_dat <= I_sram_dat;
                    end
                end
                ACK: begin
                    state    <= IDLE;
                    O_wb_ack <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    O_wb_ack <= 1'b0;
                end
            endcase
        end
    end

`ifdef VGA_SRAM_STALL_CNT_EN
    // Count edges where an idle CPU strobe was pushed back by VGA, saturating.
    always_ff @(posedge I_vga_clk) begin
        if (I_reset) begin
            O_stall_cnt <= '0;
        end else if ((state == IDLE) && I_wb_stb && I_vga_req && (O_stall_cnt != 16'hFFFF)) begin
            O_stall_cnt <= O_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sram_responder.sv
// tb_vga_sram_responder: directed bench for vga_sram_responder with an
// asynchronous SRAM model and scoreboards for VGA and CPU read data.
module tb_vga_sram_responder;

    localparam int ADR_W = 19;
    localparam int DAT_W = 8;

    typedef struct {
        bit         is_read;
        logic [7:0] data;
    } cpu_exp_t;

    logic             clk;
    logic             reset;
    logic             vga_req;
    logic [ADR_W-1:0] vga_adr;
    logic [DAT_W-1:0] vga_dat;
    logic [ADR_W-1:0] wb_adr;
    logic [DAT_W-1:0] wb_wdat;
    logic             wb_stb;
    logic             wb_we;
    logic             wb_ack;
    logic [DAT_W-1:0] wb_rdat;
    logic [ADR_W-1:0] sram_adr;
    logic [DAT_W-1:0] sram_wdata;
    logic             sram_dat_oe;
    logic [DAT_W-1:0] sram_rdata;
    logic             sram_ce_n;
    logic             sram_oe_n;
    logic             sram_we_n;
`ifdef VGA_SRAM_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    logic [7:0]  sram_mem [0:(1<<ADR_W)-1];
    logic [7:0]  vga_q [$];
    cpu_exp_t    cpu_q [$];

    int          tests_run;
    int          tests_failed;
    int          ack_cnt;
    int          we_low_cnt;
    bit          ack_seen;
    bit          vga_prev;
    logic [7:0]  last_rd;
    logic [7:0]  last_wr_dat;

    vga_sram_responder #(.ADR_W(ADR_W), .DAT_W(DAT_W)) dut (
        .I_vga_clk     (clk),
        .I_reset       (reset),
        .I_vga_req     (vga_req),
        .I_vga_adr     (vga_adr),
        .O_vga_dat     (vga_dat),
        .I_wb_adr      (wb_adr),
        .I_wb_dat      (wb_wdat),
        .I_wb_stb      (wb_stb),
        .I_wb_we       (wb_we),
        .O_wb_ack      (wb_ack),
        .O_wb_dat      (wb_rdat),
        .O_sram_adr    (sram_adr),
        .O_sram_dat    (sram_wdata),
        .O_sram_dat_oe (sram_dat_oe),
        .I_sram_dat    (sram_rdata),
        .O_sram_ce_n   (sram_ce_n),
        .O_sram_oe_n   (sram_oe_n),
        .O_sram_we_n   (sram_we_n)
`ifdef VGA_SRAM_STALL_CNT_EN
        ,
        .O_stall_cnt   (stall_cnt)
`endif
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM read path: data appears while chip and output are enabled.
    assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_adr] : 8'h00;

    function automatic logic [7:0] pattern(input logic [ADR_W-1:0] a);
        return a[7:0] ^ {a[13:8], a[18:17]} ^ 8'h3C;
    endfunction

    function automatic logic [7:0] expected_byte(input logic [ADR_W-1:0] a);
        return (a == 19'h20010) ? 8'hA5 : pattern(a);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: models SRAM writes, checks slot pins and pops scoreboards.
    task automatic applyStimulus();
        bit               req_now;
        bit               rst_now;
        bit               wr_en;
        logic [ADR_W-1:0] adr_now;
        logic [ADR_W-1:0] wa;
        logic [7:0]       wd;
        cpu_exp_t         e;
        req_now = vga_req;
        rst_now = reset;
        adr_now = vga_adr;
        wr_en   = !sram_ce_n && !sram_we_n && sram_dat_oe;
        wa      = sram_adr;
        wd      = sram_wdata;
        @(posedge clk);
        if (wr_en) sram_mem[wa] = wd;
        #1;
        ack_seen = wb_ack;
        if (rst_now) begin
            vga_prev = 1'b0;
            return;
        end
        if (vga_prev) begin
            if (vga_q.size() == 0) checkOutput("vga_q_underflow", 32'd0, 32'd1);
            else checkOutput("vga_dat_g1", 32'(vga_dat), 32'(vga_q.pop_front()));
        end
        if (req_now) begin
            checkOutput("vga_slot_adr", 32'(sram_adr), 32'(adr_now));
            checkOutput("vga_slot_oe_n", 32'(sram_oe_n), 32'd0);
            checkOutput("vga_slot_we_n", 32'(sram_we_n), 32'd1);
            vga_q.push_back(expected_byte(adr_now));
        end
        if (!sram_we_n) begin
            we_low_cnt++;
            last_wr_dat = sram_wdata;
            checkOutput("write_dat_oe", 32'(sram_dat_oe), 32'd1);
        end
        if (wb_ack) begin
            ack_cnt++;
            if (cpu_q.size() == 0) begin
                checkOutput("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = cpu_q.pop_front();
                if (e.is_read) last_rd = e.data;
                checkOutput(e.is_read ? "cpu_read_dat" : "cpu_write_keeps_dat", 32'(wb_rdat), 32'(last_rd));
            end
        end
        vga_prev = req_now;
    endtask

    // Hold the strobe until ack (bounded), then release it.
    task automatic cpuAccess(input bit we, input logic [ADR_W-1:0] adr, input logic [7:0] dat);
        cpu_exp_t e;
        bit       done;
        e.is_read = !we;
        e.data    = dat;
        cpu_q.push_back(e);
        wb_stb  = 1'b1;
        wb_we   = we;
        wb_adr  = adr;
        wb_wdat = dat;
        done    = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            applyStimulus();
            if (ack_seen) done = 1'b1;
        end
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        if (!done) checkOutput("cpu_ack_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int ack_base;
        int n;
        int wr_issued;
        cpu_exp_t e;
        tests_run    = 0;
        tests_failed = 0;
        ack_cnt      = 0;
        we_low_cnt   = 0;
        ack_seen     = 1'b0;
        vga_prev     = 1'b0;
        last_rd      = 8'h00;
        last_wr_dat  = 8'h00;
        for (int a = 0; a < (1 << ADR_W); a++) sram_mem[a] = pattern(ADR_W'(a));
        sram_mem[19'h20010] = 8'hA5;

        // Reset held two cycles while both requesters are active.
        reset   = 1'b1;
        vga_req = 1'b1;
        vga_adr = 19'h20010;
        wb_stb  = 1'b1;
        wb_we   = 1'b1;
        wb_adr  = 19'h00055;
        wb_wdat = 8'hEE;
        for (int i = 0; i < 2; i++) begin
            applyStimulus();
            checkOutput("rst_ce_n", 32'(sram_ce_n), 32'd1);
            checkOutput("rst_oe_n", 32'(sram_oe_n), 32'd1);
            checkOutput("rst_we_n", 32'(sram_we_n), 32'd1);
            checkOutput("rst_dat_oe", 32'(sram_dat_oe), 32'd0);
            checkOutput("rst_ack", 32'(wb_ack), 32'd0);
            checkOutput("rst_vga_dat", 32'(vga_dat), 32'd0);
            checkOutput("rst_sram_adr", 32'(sram_adr), 32'd0);
            checkOutput("rst_wb_dat", 32'(wb_rdat), 32'd0);
        end
        reset   = 1'b0;
        vga_req = 1'b0;
        wb_stb  = 1'b0;
        wb_we   = 1'b0;
        applyStimulus();
`ifdef VGA_SRAM_STALL_CNT_EN
        checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif

        // Single VGA read with pass-through in the slot and hold afterwards.
        vga_req = 1'b1;
        vga_adr = 19'h20010;
        applyStimulus();
        checkOutput("vga_passthru", 32'(vga_dat), 32'hA5);
        vga_req = 1'b0;
        applyStimulus();
        for (int i = 0; i < 10; i++) applyStimulus();
        checkOutput("vga_hold_10", 32'(vga_dat), 32'hA5);

        // CPU write then read back of the same byte.
        ack_base   = ack_cnt;
        we_low_cnt = 0;
        cpuAccess(1'b1, 19'h00123, 8'h5C);
        for (int i = 0; i < 3; i++) applyStimulus();
        checkOutput("wr_we_low_cycles", 32'(we_low_cnt), 32'd1);
        checkOutput("wr_sram_dat", 32'(last_wr_dat), 32'h5C);
        checkOutput("wr_ack_pulses", 32'(ack_cnt - ack_base), 32'd1);
        checkOutput("wr_mem", 32'(sram_mem[19'h00123]), 32'h5C);
        ack_base = ack_cnt;
        cpuAccess(1'b0, 19'h00123, 8'h5C);
        for (int i = 0; i < 3; i++) applyStimulus();
        checkOutput("rd_wb_dat", 32'(wb_rdat), 32'h5C);
        checkOutput("rd_ack_pulses", 32'(ack_cnt - ack_base), 32'd1);

        // Contention: VGA at edges 0 and 2, CPU read must land at edge 1.
        ack_base  = ack_cnt;
        e.is_read = 1'b1;
        e.data    = pattern(19'h00004);
        cpu_q.push_back(e);
        wb_stb  = 1'b1;
        wb_we   = 1'b0;
        wb_adr  = 19'h00004;
        vga_req = 1'b1;
        vga_adr = 19'h20020;
        applyStimulus();
        vga_req = 1'b0;
        applyStimulus();
        checkOutput("cont_cpu_adr", 32'(sram_adr), 32'h00004);
        checkOutput("cont_cpu_oe_n", 32'(sram_oe_n), 32'd0);
        vga_req = 1'b1;
        vga_adr = 19'h20021;
        applyStimulus();
        checkOutput("cont_ack_edge2", 32'(wb_ack), 32'd1);
        wb_stb  = 1'b0;
        vga_req = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus();
        checkOutput("cont_ack_pulses", 32'(ack_cnt - ack_base), 32'd1);
        checkOutput("cont_wb_dat", 32'(wb_rdat), 32'(pattern(19'h00004)));
`ifdef VGA_SRAM_STALL_CNT_EN
        checkOutput("cont_stall_cnt", 32'(stall_cnt), 32'd1);
`endif

        // Graphics stream with back-to-back CPU writes in the gaps.
        ack_base  = ack_cnt;
        n         = 0;
        wr_issued = 0;
        for (int c = 0; c < 700; c++) begin
            if ((c % 2 == 0) && (n < 320)) begin
                vga_req = 1'b1;
                vga_adr = 19'h20000 + ADR_W'(n);
                n++;
            end else begin
                vga_req = 1'b0;
            end
            if (!wb_stb && (wr_issued < 16)) begin
                e.is_read = 1'b0;
                e.data    = 8'hC0 + 8'(wr_issued);
                cpu_q.push_back(e);
                wb_stb  = 1'b1;
                wb_we   = 1'b1;
                wb_adr  = 19'h00100 + ADR_W'(wr_issued);
                wb_wdat = 8'hC0 + 8'(wr_issued);
                wr_issued++;
            end
            applyStimulus();
            if (ack_seen) begin
                wb_stb = 1'b0;
                wb_we  = 1'b0;
            end
        end
        vga_req = 1'b0;
        wb_stb  = 1'b0;
        applyStimulus();
        checkOutput("stream_acks", 32'(ack_cnt - ack_base), 32'd16);
        checkOutput("stream_vga_q_empty", 32'(vga_q.size()), 32'd0);
        checkOutput("stream_cpu_q_empty", 32'(cpu_q.size()), 32'd0);
        for (int i = 0; i < 16; i++) begin
            checkOutput("stream_wr_mem", 32'(sram_mem[19'h00100 + i]), 32'(8'hC0 + 8'(i)));
        end

        // Reset arriving while a CPU write is in its slot.
        ack_base = ack_cnt;
        wb_stb   = 1'b1;
        wb_we    = 1'b1;
        wb_adr   = 19'h00200;
        wb_wdat  = 8'h77;
        applyStimulus();
        checkOutput("midrst_we_low", 32'(sram_we_n), 32'd0);
        reset = 1'b1;
        applyStimulus();
        checkOutput("midrst_ack", 32'(wb_ack), 32'd0);
        checkOutput("midrst_we_n", 32'(sram_we_n), 32'd1);
        checkOutput("midrst_dat_oe", 32'(sram_dat_oe), 32'd0);
        reset  = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus();
        checkOutput("midrst_no_ack", 32'(ack_cnt - ack_base), 32'd0);
`ifdef VGA_SRAM_STALL_CNT_EN
        checkOutput("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
